// File: rtl/serial_shifter_param.sv
// serial_shifter_param
//   Bit-serial shifter. Operand A and shift amount B arrive LSB-first, one bit per
//   cycle, starting on the accepted start cycle. The XLEN-bit result is returned
//   LSB-first after an optional alignment phase.
//   Supported operations: SLL, SRL, SRA, ROL, ROR. Any other func code passes A
//   through unchanged.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active low
//   start      begin an operation (accepted only while idle)
//   func[2:0]  operation code, captured on the accepted start cycle
//   opA        operand A serial bit, LSB first
//   opB        operand B serial bit, LSB first (only the low SHAMT_W bits are kept)
//   busy       operation in progress
//   out        result serial bit, LSB first (0 when out_valid is low)
//   out_valid  result bit valid (XLEN consecutive cycles per operation)
//   out_last   final result bit
module serial_shifter_param #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned SHAMT_W = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [2:0] func,
   input  logic       opA,
   input  logic       opB,
   output logic       busy,
   output logic       out,
   output logic       out_valid,
   output logic       out_last
);

   localparam int unsigned CW = SHAMT_W + 1;
   localparam logic [CW-1:0] CntLast = CW'(XLEN - 1);
   localparam logic [CW-1:0] CntXlen = CW'(XLEN);

   localparam logic [2:0] FnSll = 3'b000;
   localparam logic [2:0] FnSrl = 3'b001;
   localparam logic [2:0] FnSra = 3'b011;
   localparam logic [2:0] FnRol = 3'b100;
   localparam logic [2:0] FnRor = 3'b101;

   typedef enum logic [1:0] {StIdle, StLoad, StAlign, StOut} state_e;

   state_e              state_q, state_d;
   logic [XLEN-1:0]     data_q, data_d;
   logic [SHAMT_W-1:0]  shamt_q, shamt_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                sign_q, sign_d;
   logic [2:0]          func_q, func_d;

   logic                pass_thru;
   logic                rot_left;
   logic [SHAMT_W-1:0]  sh_eff;
   logic [CW-1:0]       sh_ext;

   // Reserved codes behave as a zero-distance shift.
   always_comb begin
      pass_thru = !(func_q == FnSll || func_q == FnSrl || func_q == FnSra ||
                    func_q == FnRol || func_q == FnRor);
      rot_left  = (func_q == FnSll) || (func_q == FnRol);
      sh_eff    = pass_thru ? '0 : shamt_q;
      sh_ext    = {1'b0, sh_eff};
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      shamt_d = shamt_q;
      cnt_d   = cnt_q;
      sign_d  = sign_q;
      func_d  = func_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               // The start cycle already carries bit 0 of both operands.
               func_d    = func;
               data_d    = '0;
               data_d[0] = opA;
               shamt_d   = '0;
               shamt_d[0] = opB;
               sign_d    = 1'b0;
               cnt_d     = CW'(1);
               state_d   = StLoad;
            end
         end
         StLoad: begin
            data_d[cnt_q[SHAMT_W-1:0]] = opA;
            for (int k = 0; k < int'(SHAMT_W); k++) begin
               if (cnt_q == CW'(k)) shamt_d[k] = opB;
            end
            if (cnt_q == CntLast) begin
               // shamt is complete here since SHAMT_W < XLEN.
               sign_d  = opA;
               cnt_d   = '0;
               state_d = (sh_eff != '0) ? StAlign : StOut;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         StAlign: begin
            if (rot_left) data_d = {data_q[XLEN-2:0], data_q[XLEN-1]};
            else          data_d = {data_q[0], data_q[XLEN-1:1]};
            if ((cnt_q + CW'(1)) == sh_ext) begin
               cnt_d   = '0;
               state_d = StOut;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         StOut: begin
            data_d = {data_q[0], data_q[XLEN-1:1]};
            if (cnt_q == CntLast) begin
               cnt_d   = '0;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs depend only on registered state.
   always_comb begin
      busy      = (state_q != StIdle);
      out       = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      if (state_q == StOut) begin
         out_valid = 1'b1;
         out_last  = (cnt_q == CntLast);
         case (func_q)
            FnSll:   out = (cnt_q < sh_ext) ? 1'b0 : data_q[0];
            FnSrl:   out = (cnt_q >= (CntXlen - sh_ext)) ? 1'b0 : data_q[0];
            FnSra:   out = (cnt_q >= (CntXlen - sh_ext)) ? sign_q : data_q[0];
            default: out = data_q[0];
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
         data_q  <= '0;
         shamt_q <= '0;
         cnt_q   <= '0;
         sign_q  <= 1'b0;
         func_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         shamt_q <= shamt_d;
         cnt_q   <= cnt_d;
         sign_q  <= sign_d;
         func_q  <= func_d;
      end
   end

endmodule

// File: tb/tb_serial_shifter_param.sv
module tb_serial_shifter_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic       rst32, start32, opA32, opB32, busy32, out32, valid32, last32;
   logic [2:0] func32;
   logic       rst64, start64, opA64, opB64, busy64, out64, valid64, last64;
   logic [2:0] func64;

   serial_shifter_param #(.XLEN(32), .SHAMT_W(5)) dut32 (
      .clk(clk), .rst(rst32), .start(start32), .func(func32), .opA(opA32), .opB(opB32),
      .busy(busy32), .out(out32), .out_valid(valid32), .out_last(last32)
   );

   serial_shifter_param #(.XLEN(64), .SHAMT_W(6)) dut64 (
      .clk(clk), .rst(rst64), .start(start64), .func(func64), .opA(opA64), .opB(opB64),
      .busy(busy64), .out(out64), .out_valid(valid64), .out_last(last64)
   );

   typedef struct {
      logic [63:0] res;
      int          first;
      int          last;
   } exp_t;

   typedef struct {
      bit          w64;
      logic [2:0]  f;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] res;
      int          sh;
      bit          pulse;
      bit          abort;
   } vec_t;

   exp_t q32[$];
   exp_t q64[$];
   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Monitors: collect result bits and compare against the scoreboard on out_last.
   logic [63:0] acc32 = '0, acc64 = '0;
   int          n32 = 0, n64 = 0, first32 = 0, first64 = 0;
   exp_t        e32, e64;

   always @(negedge clk) begin
      if (rst32) begin
         if (!valid32) begin
            check("out32 gated", 64'(out32), 64'd0);
            check("last32 gated", 64'(last32), 64'd0);
         end else begin
            if (n32 == 0) first32 = cyc;
            if (n32 < 64) acc32[n32] = out32;
            n32++;
            if (last32) begin
               if (q32.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected32: result 0x%0h with no pending op", acc32);
               end else begin
                  e32 = q32.pop_front();
                  check("result32", acc32, e32.res);
                  check("first32", 64'(first32), 64'(e32.first));
                  check("last32", 64'(cyc), 64'(e32.last));
                  check("count32", 64'(n32), 64'd32);
               end
               n32   = 0;
               acc32 = '0;
            end
         end
      end else begin
         n32   = 0;
         acc32 = '0;
      end
   end

   always @(negedge clk) begin
      if (rst64) begin
         if (!valid64) begin
            check("out64 gated", 64'(out64), 64'd0);
            check("last64 gated", 64'(last64), 64'd0);
         end else begin
            if (n64 == 0) first64 = cyc;
            if (n64 < 64) acc64[n64] = out64;
            n64++;
            if (last64) begin
               if (q64.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected64: result 0x%0h with no pending op", acc64);
               end else begin
                  e64 = q64.pop_front();
                  check("result64", acc64, e64.res);
                  check("first64", 64'(first64), 64'(e64.first));
                  check("last64", 64'(cyc), 64'(e64.last));
                  check("count64", 64'(n64), 64'd64);
               end
               n64   = 0;
               acc64 = '0;
            end
         end
      end else begin
         n64   = 0;
         acc64 = '0;
      end
   end

   task automatic drive(input bit w64, input logic s, input logic [2:0] f, input logic a,
                        input logic b);
      if (w64) begin
         start64 = s; func64 = f; opA64 = a; opB64 = b;
      end else begin
         start32 = s; func32 = f; opA32 = a; opB32 = b;
      end
   endtask

   task automatic wait_idle(input bit w64);
      int n;
      n = 0;
      while ((w64 ? busy64 : busy32) && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 500) begin
         checks++;
         errors++;
         $display("FAIL idle timeout: busy still 1, required 0 (w64=%0d)", w64);
      end
   endtask

   task automatic run_op(input vec_t v);
      int t;
      int w;
      exp_t e;
      w = v.w64 ? 64 : 32;
      wait_idle(v.w64);
      t = cyc;
      if (!v.abort) begin
         e.res   = v.res;
         e.first = t + w + v.sh;
         e.last  = t + 2 * w + v.sh - 1;
         if (v.w64) q64.push_back(e);
         else       q32.push_back(e);
      end
      for (int k = 0; k < w; k++) begin
         drive(v.w64, (k == 0) || (v.pulse && (k % 5 == 2)),
               (k == 0 || !v.pulse) ? v.f : ~v.f, v.a[k], v.b[k]);
         @(posedge clk);
         #1;
      end
      drive(v.w64, 1'b0, 3'b000, 1'b0, 1'b0);
      if (v.pulse) begin
         for (int k = 0; k < 16; k++) begin
            drive(v.w64, (k % 2 == 0), ~v.f, 1'b1, 1'b1);
            @(posedge clk);
            #1;
         end
         drive(v.w64, 1'b0, 3'b000, 1'b0, 1'b0);
      end
      if (v.abort) begin
         repeat (3) begin
            @(posedge clk);
            #1;
         end
         rst32 = 1'b0;
         @(posedge clk);
         #1;
         rst32 = 1'b1;
         check("abort busy", 64'(busy32), 64'd0);
         check("abort valid", 64'(valid32), 64'd0);
         check("abort out", 64'(out32), 64'd0);
         @(posedge clk);
         #1;
         check("abort busy+1", 64'(busy32), 64'd0);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst32 = 1'b0; rst64 = 1'b0;
      drive(1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("reset busy32", 64'(busy32), 64'd0);
      check("reset valid32", 64'(valid32), 64'd0);
      check("reset last32", 64'(last32), 64'd0);
      check("reset busy64", 64'(busy64), 64'd0);
      check("reset valid64", 64'(valid64), 64'd0);
      rst32 = 1'b1; rst64 = 1'b1;
      @(posedge clk);
      #1;

      vecs.push_back('{1'b0, 3'b000, 64'h0000_00F1, 64'd4, 64'h0000_0F10, 4, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 3'b011, 64'h8000_0010, 64'd4, 64'hF800_0001, 4, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 3'b001, 64'h8000_0010, 64'd4, 64'h0800_0001, 4, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 3'b101, 64'h0000_0001, 64'd1, 64'h8000_0000, 1, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 3'b100, 64'h8000_0001, 64'd31, 64'hC000_0000, 31, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 3'b001, 64'hDEAD_BEEF, 64'hFFFF_FFE0, 64'hDEAD_BEEF, 0, 1'b0,
                       1'b0});
      vecs.push_back('{1'b0, 3'b000, 64'h1234_5678, 64'd8, 64'h3456_7800, 8, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 3'b100, 64'h1234_5678, 64'd4, 64'h2345_6781, 4, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 3'b010, 64'hCAFE_F00D, 64'd5, 64'hCAFE_F00D, 0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 3'b000, 64'hFFFF_FFFF, 64'd20, 64'd0, 20, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 3'b011, 64'h8000_0000, 64'd31, 64'hFFFF_FFFF, 31, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 3'b001, 64'h8000_0000_0000_0000, 64'd63, 64'd1, 63, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 3'b111, 64'h0123_4567_89AB_CDEF, 64'd9, 64'h0123_4567_89AB_CDEF,
                       0, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 3'b000, 64'd1, 64'd63, 64'h8000_0000_0000_0000, 63, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 3'b011, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000,
                       4, 1'b0, 1'b0});

      foreach (vecs[i]) run_op(vecs[i]);

      wait_idle(1'b0);
      wait_idle(1'b1);
      repeat (3) @(posedge clk);
      #1;
      check("q32 drained", 64'(q32.size()), 64'd0);
      check("q64 drained", 64'(q64.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
